// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, types and the write bundle
package rf_pkg;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;
  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;
  typedef struct packed {
    logic     we;
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester bus plus register-file write port bundle
interface rf_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW
);
  localparam int IW = idx_w(NUM_REQ);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  stall;
  logic [NUM_REQ-1:0]    ack;
  logic                  rf_writeEn;
  logic [AW-1:0]         rf_writeAdd;
  logic [DW-1:0]         rf_Din;
  logic [IW-1:0]         last_gnt;
  logic                  busy;
  modport master (
    output req, req_addr, req_data, stall,
    input  ack, rf_writeEn, rf_writeAdd, rf_Din, last_gnt, busy
  );
  modport slave (
    input  req, req_addr, req_data, stall,
    output ack, rf_writeEn, rf_writeAdd, rf_Din, last_gnt, busy
  );
endinterface

// File: rtl/rf_write_arbiter_rr.sv
// rr_arbiter: round-robin one-hot arbiter; search starts at ptr and wraps
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW     = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_stall,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_gnt_idx,
  output logic               o_valid
);
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_hit;
  int            w_j;
  // first requester at or after ptr (modulo NUM_REQ); stall and reset suppress the grant
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_j   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = int'(r_ptr) + i;
      w_j = (w_j >= NUM_REQ) ? w_j - NUM_REQ : w_j;
      if (!w_hit && i_req[IW'(w_j)]) begin
        w_hit = 1'b1;
        w_idx = IW'(w_j);
      end
    end
    o_valid   = w_hit && !i_stall && !rst;
    o_gnt     = o_valid ? (NUM_REQ'(1) << w_idx) : '0;
    o_gnt_idx = w_idx;
  end
  // priority moves just past the winner; holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (o_valid) r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port; RF_WRITE_ARB_R0_DISCARD_EN drops writes to r0
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW
) (
  input  logic                clk,
  input  logic                rst,
  rf_write_arbiter_if.slave   bus
);
  localparam int IW = idx_w(NUM_REQ);
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_valid;
  logic               w_we;
  rf_addr_t           w_addr;
  rf_data_t           w_data;
  rf_wr_t             r_wr;
  logic [IW-1:0]      r_last_gnt;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.req),
    .i_stall   (bus.stall),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_idx),
    .o_valid   (w_valid)
  );
  // select the winner's address/data; an r0 write is accepted but never reaches the file when discard is built in
  always_comb begin
    w_addr = bus.req_addr[int'(w_idx)*AW +: AW];
    w_data = bus.req_data[int'(w_idx)*DW +: DW];
`ifdef RF_WRITE_ARB_R0_DISCARD_EN
    w_we   = w_valid && (w_addr != '0);
`else
    w_we   = w_valid;
`endif
  end
  // output stage: enable pulses for one cycle per write, address/data hold between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= '0;
      r_last_gnt <= '0;
    end else begin
      r_wr.we <= w_we;
      if (w_we) begin
        r_wr.addr <= w_addr;
        r_wr.data <= w_data;
      end
      if (w_valid) r_last_gnt <= w_idx;
    end
  end
  assign bus.ack         = w_gnt;
  assign bus.busy        = |(bus.req & ~w_gnt);
  assign bus.rf_writeEn  = r_wr.we;
  assign bus.rf_writeAdd = r_wr.addr;
  assign bus.rf_Din      = r_wr.data;
  assign bus.last_gnt    = r_last_gnt;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, corner sequences and randomized run against a reference model
module tb_rf_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rf_write_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();
  rf_write_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [N-1:0] req;
    logic         stall;
    logic [N-1:0] ack;
    logic         busy;
  } row_t;
  row_t tbl [17];
  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int m_win   = -1;
  int m_last  = 0;
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
`ifdef RF_WRITE_ARB_R0_DISCARD_EN
  localparam bit DISCARD = 1'b1;
`else
  localparam bit DISCARD = 1'b0;
`endif
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (p + i) % N;
      if (r[k[1:0]]) return k;
    end
    return -1;
  endfunction
  task automatic step(input string tag);
    logic [N-1:0] ea;
    logic [AW-1:0] wa;
    #2;
    m_win = (rst || bus.stall) ? -1 : pick(bus.req, m_ptr);
    ea = (m_win < 0) ? '0 : N'(1) << m_win;
    chk({tag, " ack"}, 64'(bus.ack), 64'(ea));
    chk({tag, " busy"}, 64'(bus.busy), 64'(|(bus.req & ~ea)));
    wa = (m_win < 0) ? '0 : bus.req_addr[m_win*AW +: AW];
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_last = 0;
    end else begin
      m_we = (m_win >= 0) && !(DISCARD && wa == '0);
      if (m_we) begin
        m_addr = wa;
        m_data = bus.req_data[m_win*DW +: DW];
      end
      if (m_win >= 0) begin
        m_ptr  = (m_win + 1) % N;
        m_last = m_win;
      end
    end
    #1;
    chk({tag, " writeEn"}, 64'(bus.rf_writeEn), 64'(m_we));
    chk({tag, " writeAdd"}, 64'(bus.rf_writeAdd), 64'(m_addr));
    chk({tag, " Din"}, 64'(bus.rf_Din), 64'(m_data));
    chk({tag, " last_gnt"}, 64'(bus.last_gnt), 64'(m_last));
  endtask
  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 1'b0, N'(1) << (i % 4), 1'b1};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0000, 1'b1};
    tbl[9]  = '{4'b1010, 1'b1, 4'b0000, 1'b1};
    tbl[10] = '{4'b1010, 1'b1, 4'b0000, 1'b1};
    tbl[11] = '{4'b1010, 1'b0, 4'b0010, 1'b1};
    tbl[12] = '{4'b1001, 1'b0, 4'b1000, 1'b1};
    tbl[13] = '{4'b0110, 1'b0, 4'b0010, 1'b1};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[15] = '{4'b0011, 1'b0, 4'b0001, 1'b1};
    tbl[16] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    bus.req = '1; bus.stall = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    for (int k = 0; k < N; k++) begin
      bus.req_addr[k*AW +: AW] = AW'(k * 3 + 1);
      bus.req_data[k*DW +: DW] = 32'hA000_0000 | k;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step("reset0");
    step("reset1");
    chk("reset ack", 64'(bus.ack), 64'(0));
    chk("reset writeEn", 64'(bus.rf_writeEn), 64'(0));
    chk("reset writeAdd", 64'(bus.rf_writeAdd), 64'(0));
    chk("reset Din", 64'(bus.rf_Din), 64'(0));
    chk("reset last_gnt", 64'(bus.last_gnt), 64'(0));
    rst = 1'b0;
    bus.req = 4'b0100;
    bus.req_addr[2*AW +: AW] = 5'd7;
    bus.req_data[2*DW +: DW] = 32'hDEADBEEF;
    #2 chk("single ack", 64'(bus.ack), 64'(4'b0100));
    step("single");
    chk("single writeEn", 64'(bus.rf_writeEn), 64'(1));
    chk("single writeAdd", 64'(bus.rf_writeAdd), 64'(7));
    chk("single Din", 64'(bus.rf_Din), 64'(32'hDEADBEEF));
    chk("single last_gnt", 64'(bus.last_gnt), 64'(2));
    bus.req_addr[2*AW +: AW] = 5'd7;
    rst = 1'b1; bus.req = '0;
    step("rerst");
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.req = tbl[i].req;
      bus.stall = tbl[i].stall;
      #2;
      chk($sformatf("row%0d ack", i), 64'(bus.ack), 64'(tbl[i].ack));
      chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'(tbl[i].busy));
      step($sformatf("row%0d", i));
      chk($sformatf("row%0d writeEn", i), 64'(bus.rf_writeEn), 64'(tbl[i].ack != '0));
    end
    bus.req = 4'b0010; bus.stall = 1'b0;
    bus.req_addr[1*AW +: AW] = 5'd9;
    step("midrst accept");
    chk("midrst accept writeEn", 64'(bus.rf_writeEn), 64'(1));
    chk("midrst accept writeAdd", 64'(bus.rf_writeAdd), 64'(9));
    rst = 1'b1; bus.req = '0;
    step("midrst drop");
    chk("midrst drop writeEn", 64'(bus.rf_writeEn), 64'(0));
    rst = 1'b0;
    bus.req = 4'b0001;
    bus.req_addr[0 +: AW] = '0;
    bus.req_data[0 +: DW] = 32'h1234;
    #2 chk("r0 ack", 64'(bus.ack), 64'(4'b0001));
    step("r0");
    chk("r0 writeEn", 64'(bus.rf_writeEn), 64'(!DISCARD));
    if (!DISCARD) chk("r0 writeAdd", 64'(bus.rf_writeAdd), 64'(0));
    bus.req = 4'b0011;
    #2 chk("r0 ptr advanced", 64'(bus.ack), 64'(4'b0010));
    step("r0 next");
    bus.req = '0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        if ((bus.req[k] && k == m_win) || !bus.req[k]) begin
          bus.req[k] = 1'($urandom_range(0, 1));
          bus.req_addr[k*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          bus.req_data[k*DW +: DW] = $urandom;
        end
      end
      step($sformatf("rand%0d", c));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
